// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb engine: grid geometry, bomb value
// encodings, FSM state and blast-arm direction enums, and the cell
// index helper used by every block that addresses the 10x10 grid.
package bomb_pkg;

  localparam int GRID  = 10;
  localparam int CELLS = 100;

  localparam logic [1:0] BOMB_FRESH = 2'd3;
  localparam logic [1:0] BOMB_FIRE  = 2'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    SCAN   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_XN = 2'd0,
    DIR_XP = 2'd1,
    DIR_YN = 2'd2,
    DIR_YP = 2'd3
  } dir_t;

  // Flattened cell index; x selects the row of ten, y the column.
  function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return 7'(x) * 7'd10 + 7'(y);
  endfunction

endpackage

// File: rtl/bomb_engine_blast_arm.sv
// One arm of a cross-shaped blast. Given the exploding cell and a
// direction, walks steps 1..RADIUS and reports which cells the flame
// reaches and which of those are destructible blocks to clear.
//   i_x, i_y   origin cell coordinates (0..9)
//   i_dir      arm direction
//   i_arena    working blocking map (solid | destructible)
//   i_solid    indestructible wall map
//   o_valid    step k+1 is flamed
//   o_clear    step k+1 is a destructible block that the blast removes
//   o_idx      flattened cell index of step k+1 (0 when off-grid)
module blast_arm
  import bomb_pkg::*;
#(
  parameter int RADIUS = 2
) (
  input  logic [3:0]              i_x,
  input  logic [3:0]              i_y,
  input  dir_t                    i_dir,
  input  logic [CELLS-1:0]        i_arena,
  input  logic [CELLS-1:0]        i_solid,
  output logic [RADIUS-1:0]       o_valid,
  output logic [RADIUS-1:0]       o_clear,
  output logic [RADIUS-1:0][6:0]  o_idx
);

  logic signed [4:0] w_dx;
  logic signed [4:0] w_dy;
  logic signed [4:0] w_sx;
  logic signed [4:0] w_sy;

  assign w_sx = $signed({1'b0, i_x});
  assign w_sy = $signed({1'b0, i_y});

  always_comb begin
    w_dx = 5'sd0;
    w_dy = 5'sd0;
    case (i_dir)
      DIR_XN:  w_dx = -5'sd1;
      DIR_XP:  w_dx = 5'sd1;
      DIR_YN:  w_dy = -5'sd1;
      default: w_dy = 5'sd1;
    endcase
  end

  // The arm keeps going only while every earlier step was open floor or
  // a bomb; a wall stops it before the cell, a block stops it on the cell.
  always_comb begin : p_walk
    logic              w_reach;
    logic              w_in_grid;
    logic              w_solid;
    logic              w_destr;
    logic signed [4:0] w_cx;
    logic signed [4:0] w_cy;
    logic [6:0]        w_c;
    o_valid = '0;
    o_clear = '0;
    o_idx   = '0;
    w_reach = 1'b1;
    for (int k = 0; k < RADIUS; k++) begin
      w_cx      = w_sx + w_dx * $signed(5'(k + 1));
      w_cy      = w_sy + w_dy * $signed(5'(k + 1));
      w_in_grid = (w_cx >= 5'sd0) && (w_cx <= 5'sd9) &&
                  (w_cy >= 5'sd0) && (w_cy <= 5'sd9);
      w_c       = w_in_grid ? cell_idx(w_cx[3:0], w_cy[3:0]) : 7'd0;
      w_solid   = i_solid[w_c];
      w_destr   = i_arena[w_c] & ~w_solid;
      o_idx[k]  = w_c;
      o_valid[k] = w_reach & w_in_grid & ~w_solid;
      o_clear[k] = o_valid[k] & w_destr;
      w_reach    = o_valid[k] & ~w_destr;
    end
  end

endmodule

// File: rtl/bomb_engine.sv
// Bomb engine: on each game tick ages every bomb, detonates fused bombs,
// propagates cross-shaped blasts (clearing blocks, chain-arming bombs,
// flagging players) and commits a consistent snapshot of the grids.
//   clk, rst              system clock, synchronous active-high reset
//   tick                  one-cycle game-step pulse
//   in_Bomb_bit0/1        bomb values written by the controller
//   onedim_Solid          indestructible walls
//   playerA/B x/y         player cell coordinates
//   Bomb_bit0/1           committed bomb values
//   onedim_Arena          committed blocking map
//   flame                 cells covered by blasts in the last pass
//   hitA, hitB            sticky player-hit flags
//   busy, done            pass in progress / one-cycle commit pulse
//
// state  | meaning
// IDLE   | waiting for tick
// LATCH  | copy inputs into working grids, sample players
// SCAN   | process one cell per cycle, idx 0..99
// COMMIT | publish working grids, update hit flags, pulse done
module bomb_engine
  import bomb_pkg::*;
#(
  parameter int               RADIUS     = 2,
  parameter logic [CELLS-1:0] ARENA_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [CELLS-1:0] in_Bomb_bit0,
  input  logic [CELLS-1:0] in_Bomb_bit1,
  input  logic [CELLS-1:0] onedim_Solid,
  input  logic [3:0]       playerAx,
  input  logic [3:0]       playerAy,
  input  logic [3:0]       playerBx,
  input  logic [3:0]       playerBy,
  output logic [CELLS-1:0] Bomb_bit0,
  output logic [CELLS-1:0] Bomb_bit1,
  output logic [CELLS-1:0] onedim_Arena,
  output logic [CELLS-1:0] flame,
  output logic             hitA,
  output logic             hitB,
  output logic             busy,
  output logic             done
);

  localparam logic [6:0] LAST_IDX = 7'(CELLS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CELLS-1:0] r_wb0;
  logic [CELLS-1:0] r_wb1;
  logic [CELLS-1:0] r_warena;
  logic [CELLS-1:0] r_wflame;
  logic [CELLS-1:0] r_skip;
  logic [6:0]       r_idx;
  logic [3:0]       r_x;
  logic [3:0]       r_y;
  logic [3:0]       r_ax;
  logic [3:0]       r_ay;
  logic [3:0]       r_bx;
  logic [3:0]       r_by;

  logic [RADIUS-1:0]      w_valid [4];
  logic [RADIUS-1:0]      w_clear [4];
  logic [RADIUS-1:0][6:0] w_cidx  [4];
  logic [1:0]             w_cur;
  logic                   w_hit_a;
  logic                   w_hit_b;

  for (genvar g = 0; g < 4; g++) begin : g_arm
    blast_arm #(.RADIUS(RADIUS)) u_arm (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_dir   (dir_t'(2'(g))),
      .i_arena (r_warena),
      .i_solid (onedim_Solid),
      .o_valid (w_valid[g]),
      .o_clear (w_clear[g]),
      .o_idx   (w_cidx[g])
    );
  end

  assign w_cur   = {r_wb1[r_idx], r_wb0[r_idx]};
  // Off-grid player coordinates never index the flame map.
  assign w_hit_a = (r_ax <= 4'd9) && (r_ay <= 4'd9) && r_wflame[cell_idx(r_ax, r_ay)];
  assign w_hit_b = (r_bx <= 4'd9) && (r_by <= 4'd9) && r_wflame[cell_idx(r_bx, r_by)];

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:   if (tick) w_next = LATCH;
      LATCH:  begin
        busy   = 1'b1;
        w_next = SCAN;
      end
      SCAN:   begin
        busy = 1'b1;
        if (r_idx == LAST_IDX) w_next = COMMIT;
      end
      default: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      Bomb_bit0    <= '0;
      Bomb_bit1    <= '0;
      onedim_Arena <= ARENA_INIT;
      flame        <= '0;
      hitA         <= 1'b0;
      hitB         <= 1'b0;
      r_wb0        <= '0;
      r_wb1        <= '0;
      r_warena     <= '0;
      r_wflame     <= '0;
      r_skip       <= '0;
      r_idx        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_ax         <= '0;
      r_ay         <= '0;
      r_bx         <= '0;
      r_by         <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        LATCH: begin
          r_wb0    <= in_Bomb_bit0;
          r_wb1    <= in_Bomb_bit1;
          r_warena <= onedim_Arena | onedim_Solid;
          r_wflame <= '0;
          r_skip   <= '0;
          r_idx    <= '0;
          r_x      <= '0;
          r_y      <= '0;
          r_ax     <= playerAx;
          r_ay     <= playerAy;
          r_bx     <= playerBx;
          r_by     <= playerBy;
        end
        SCAN: begin
          if (!r_skip[r_idx]) begin
            if (w_cur == BOMB_FIRE) begin
              r_wb0[r_idx]    <= 1'b0;
              r_wb1[r_idx]    <= 1'b0;
              r_wflame[r_idx] <= 1'b1;
              for (int d = 0; d < 4; d++) begin
                for (int k = 0; k < RADIUS; k++) begin
                  if (w_valid[d][k]) begin
                    r_wflame[w_cidx[d][k]] <= 1'b1;
                    if (w_clear[d][k]) begin
                      r_warena[w_cidx[d][k]] <= 1'b0;
                    end else if (r_wb0[w_cidx[d][k]] | r_wb1[w_cidx[d][k]]) begin
                      // Chain-armed: fuse to 1 and protect it for the rest of this pass.
                      r_wb0[w_cidx[d][k]]  <= 1'b1;
                      r_wb1[w_cidx[d][k]]  <= 1'b0;
                      r_skip[w_cidx[d][k]] <= 1'b1;
                    end
                  end
                end
              end
            end else if (w_cur[1]) begin
              // 3 -> 2, 2 -> 1
              r_wb0[r_idx] <= ~r_wb0[r_idx];
              r_wb1[r_idx] <= r_wb0[r_idx];
            end
          end
          r_idx <= r_idx + 7'd1;
          if (r_y == 4'd9) begin
            r_y <= 4'd0;
            r_x <= r_x + 4'd1;
          end else begin
            r_y <= r_y + 4'd1;
          end
        end
        COMMIT: begin
          Bomb_bit0    <= r_wb0;
          Bomb_bit1    <= r_wb1;
          onedim_Arena <= r_warena;
          flame        <= r_wflame;
          hitA         <= hitA | w_hit_a;
          hitB         <= hitB | w_hit_b;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_engine.sv
// Self-checking bench for bomb_engine: directed scenarios plus a
// randomized game run, all compared against a cell-by-cell model of the
// tick rules kept here.
module tb_bomb_engine;

  localparam logic [99:0] ARENA_INIT = (100'd1 << 12) | (100'd1 << 77) | (100'd1 << 83) |
                                       (100'd1 << 38) | (100'd1 << 61) | (100'd1 << 27);
  localparam int RAD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [99:0] in_Bomb_bit0 = '0;
  logic [99:0] in_Bomb_bit1 = '0;
  logic [99:0] onedim_Solid = '0;
  logic [3:0]  playerAx = 4'd15, playerAy = 4'd15, playerBx = 4'd15, playerBy = 4'd15;
  logic [99:0] Bomb_bit0, Bomb_bit1, onedim_Arena, flame;
  logic        hitA, hitB, busy, done;

  int n_checks = 0;
  int n_err    = 0;

  int m_bomb  [100];
  bit m_arena [100];
  bit m_flame [100];
  bit m_hitA, m_hitB;
  logic [99:0] d_b0, d_b1;

  bomb_engine #(.RADIUS(RAD), .ARENA_INIT(ARENA_INIT)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .in_Bomb_bit0(in_Bomb_bit0), .in_Bomb_bit1(in_Bomb_bit1), .onedim_Solid(onedim_Solid),
    .playerAx(playerAx), .playerAy(playerAy), .playerBx(playerBx), .playerBy(playerBy),
    .Bomb_bit0(Bomb_bit0), .Bomb_bit1(Bomb_bit1), .onedim_Arena(onedim_Arena), .flame(flame),
    .hitA(hitA), .hitB(hitB), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [99:0] pk_b0();
    logic [99:0] v;
    for (int i = 0; i < 100; i++) v[i] = (m_bomb[i] % 2) == 1;
    return v;
  endfunction

  function automatic logic [99:0] pk_b1();
    logic [99:0] v;
    for (int i = 0; i < 100; i++) v[i] = m_bomb[i] >= 2;
    return v;
  endfunction

  function automatic logic [99:0] pk_arena();
    logic [99:0] v;
    for (int i = 0; i < 100; i++) v[i] = m_arena[i];
    return v;
  endfunction

  function automatic logic [99:0] pk_flame();
    logic [99:0] v;
    for (int i = 0; i < 100; i++) v[i] = m_flame[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 100; i++) begin
      m_bomb[i]  = 0;
      m_arena[i] = ARENA_INIT[i];
      m_flame[i] = 0;
    end
    m_hitA = 0;
    m_hitB = 0;
  endtask

  // One game step straight from the rules: row-major walk, explode fused
  // bombs into a cross, age the rest, then publish.
  task automatic model_tick();
    int b [100];
    bit ar[100];
    bit fl[100];
    bit sk[100];
    int dxs[4];
    int dys[4];
    int nx, ny, j, ax, ay, bx, by;
    dxs = '{-1, 1, 0, 0};
    dys = '{0, 0, -1, 1};
    for (int i = 0; i < 100; i++) begin
      b[i]  = 2 * int'(d_b1[i]) + int'(d_b0[i]);
      ar[i] = m_arena[i] | onedim_Solid[i];
      fl[i] = 0;
      sk[i] = 0;
    end
    for (int x = 0; x < 10; x++) begin
      for (int y = 0; y < 10; y++) begin
        if (sk[x*10+y]) continue;
        if (b[x*10+y] == 1) begin
          b[x*10+y]  = 0;
          fl[x*10+y] = 1;
          for (int d = 0; d < 4; d++) begin
            for (int s = 1; s <= RAD; s++) begin
              nx = x + dxs[d] * s;
              ny = y + dys[d] * s;
              if (nx < 0 || nx > 9 || ny < 0 || ny > 9) break;
              j = nx * 10 + ny;
              if (onedim_Solid[j]) break;
              if (ar[j]) begin
                ar[j] = 0;
                fl[j] = 1;
                break;
              end
              fl[j] = 1;
              if (b[j] >= 1) begin
                b[j]  = 1;
                sk[j] = 1;
              end
            end
          end
        end else if (b[x*10+y] >= 2) begin
          b[x*10+y]--;
        end
      end
    end
    for (int i = 0; i < 100; i++) begin
      m_bomb[i]  = b[i];
      m_arena[i] = ar[i];
      m_flame[i] = fl[i];
    end
    ax = playerAx; ay = playerAy; bx = playerBx; by = playerBy;
    if (ax <= 9 && ay <= 9 && fl[ax*10+ay]) m_hitA = 1;
    if (bx <= 9 && by <= 9 && fl[bx*10+by]) m_hitB = 1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".b0"},    Bomb_bit0,    pk_b0());
    chk({tag, ".b1"},    Bomb_bit1,    pk_b1());
    chk({tag, ".arena"}, onedim_Arena, pk_arena());
    chk({tag, ".flame"}, flame,        pk_flame());
    chk({tag, ".hitA"},  hitA,         m_hitA);
    chk({tag, ".hitB"},  hitB,         m_hitB);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic echo_bombs();
    d_b0 = pk_b0();
    d_b1 = pk_b1();
  endtask

  task automatic run_tick(input string tag);
    int lat;
    in_Bomb_bit0 = d_b0;
    in_Bomb_bit1 = d_b1;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    lat = 1;
    while (lat < 200 && !done) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, 102);
    @(negedge clk);
    model_tick();
    compare_all(tag);
  endtask

  initial begin
    logic [99:0] exp_v;
    int ndone, c, v;

    onedim_Solid = (100'd1 << 21) | (100'd1 << 88) | (100'd1 << 72);
    do_reset();
    chk("rst.b0", Bomb_bit0, 100'd0);
    chk("rst.b1", Bomb_bit1, 100'd0);
    chk("rst.arena", onedim_Arena, ARENA_INIT);
    chk("rst.flame", flame, 100'd0);
    chk("rst.hits", {hitA, hitB}, 2'b00);
    chk("rst.busy_done", {busy, done}, 2'b00);

    // Single fresh bomb ageing out.
    d_b0 = '0; d_b1 = '0;
    d_b0[55] = 1'b1; d_b1[55] = 1'b1;
    run_tick("single1");
    chk("single1.val", {Bomb_bit1[55], Bomb_bit0[55]}, 2'd2);
    echo_bombs();
    run_tick("single2");
    chk("single2.val", {Bomb_bit1[55], Bomb_bit0[55]}, 2'd1);
    echo_bombs();
    run_tick("single3");
    exp_v = '0;
    exp_v[35] = 1; exp_v[45] = 1; exp_v[55] = 1; exp_v[65] = 1; exp_v[75] = 1;
    exp_v[53] = 1; exp_v[54] = 1; exp_v[56] = 1; exp_v[57] = 1;
    chk("single3.flame_cross", flame, exp_v);
    chk("single3.flame_cnt", $countones(flame), 9);

    // Block and wall next to a fused bomb.
    do_reset();
    d_b0 = '0; d_b1 = '0;
    d_b0[11] = 1'b1;
    run_tick("block");
    chk("block.arena12", onedim_Arena[12], 1'b0);
    chk("block.flame12", flame[12], 1'b1);
    chk("block.flame13", flame[13], 1'b0);
    chk("block.arena21", onedim_Arena[21], 1'b1);
    chk("block.flame21", flame[21], 1'b0);
    chk("block.flame01", flame[1], 1'b1);

    // Chain reaction across one pass boundary.
    do_reset();
    d_b0 = '0; d_b1 = '0;
    d_b0[44] = 1'b1;
    d_b0[46] = 1'b1; d_b1[46] = 1'b1;
    run_tick("chain1");
    chk("chain1.val46", {Bomb_bit1[46], Bomb_bit0[46]}, 2'd1);
    echo_bombs();
    run_tick("chain2");
    chk("chain2.row", flame[48:44], 5'b11111);
    chk("chain2.val46", {Bomb_bit1[46], Bomb_bit0[46]}, 2'd0);

    // Sticky player hits.
    do_reset();
    playerAx = 4'd5; playerAy = 4'd6; playerBx = 4'd0; playerBy = 4'd9;
    d_b0 = '0; d_b1 = '0;
    d_b0[55] = 1'b1;
    run_tick("hit");
    chk("hit.A", hitA, 1'b1);
    chk("hit.B", hitB, 1'b0);
    d_b0 = '0;
    for (int i = 0; i < 3; i++) run_tick("hit_clean");
    chk("hit.sticky", hitA, 1'b1);
    do_reset();
    chk("hit.rst", {hitA, hitB}, 2'b00);
    playerAx = 4'd15; playerAy = 4'd15; playerBx = 4'd15; playerBy = 4'd15;

    // Tick during a pass is ignored.
    d_b0 = '0; d_b1 = '0;
    d_b0[55] = 1'b1; d_b1[55] = 1'b1;
    in_Bomb_bit0 = d_b0; in_Bomb_bit1 = d_b1;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (49) @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    ndone = 0;
    for (int i = 0; i < 250; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ignore.one_done", ndone, 1);
    model_tick();
    compare_all("ignore");

    // Reset in the middle of a scan.
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (50) @(negedge clk);
    chk("midrst.busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midrst.busy_done", {busy, done}, 2'b00);
    compare_all("midrst");

    // Corner bomb must not wrap.
    d_b0 = '0; d_b1 = '0;
    d_b0[0] = 1'b1;
    run_tick("edge");
    exp_v = '0;
    exp_v[0] = 1; exp_v[1] = 1; exp_v[2] = 1; exp_v[10] = 1; exp_v[20] = 1;
    chk("edge.flame", flame, exp_v);

    // Randomized game run: controller echoes the model's snapshot and
    // drops new bombs on free cells.
    do_reset();
    for (int t = 0; t < 25; t++) begin
      echo_bombs();
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
        c = $urandom_range(0, 99);
        if (!m_arena[c] && !onedim_Solid[c] && m_bomb[c] == 0) begin
          v = ($urandom_range(0, 3) == 0) ? 1 : 3;
          d_b0[c] = 1'b1;
          d_b1[c] = (v == 3);
        end
      end
      playerAx = 4'($urandom_range(0, 11));
      playerAy = 4'($urandom_range(0, 11));
      playerBx = 4'($urandom_range(0, 11));
      playerBy = 4'($urandom_range(0, 11));
      run_tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
